// File: rtl/limits_buffer_controller.sv
// Limit table store: loads per-sample {max,min} words from a packet and replays them to the hard limiter.
// Latency: limbuff_data follows iter_start/iter_advance by one cycle (registered RAM read, no bubbles).
// Backpressure: in_ready drops only while replaying; iter_advance is the limiter's consume strobe.
module limits_buffer_controller #(
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           in_data,
  input  logic                  in_valid,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  output logic                  in_ready,
  input  logic                  iter_start,
  input  logic                  iter_advance,
  output logic [31:0]           limbuff_data,
  output logic                  limbuff_valid,
  output logic                  iter_done,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   table_len,
  output logic [CNT_WIDTH-1:0]  iter_count,
  output logic                  cfg_error,
  output logic                  overflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]  DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]  ONE_W   = (ADDR_WIDTH + 1)'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READY,
    ST_REPLAY
  } state_t;

  state_t                 state, state_nxt;
  logic [31:0]            mem [DEPTH];
  logic [31:0]            rd_data;
  logic [ADDR_WIDTH:0]    wp, wp_nxt, table_len_nxt, idx_inc;
  logic [ADDR_WIDTH-1:0]  idx, idx_nxt, wr_addr;
  logic [CNT_WIDTH-1:0]   cnt_nxt;
  logic                   accept, swap, wr_en;
  logic [31:0]            wr_word;
  logic                   cfg_nxt, ovf_nxt, load_done_nxt, iter_done_nxt;

  // Loading is blocked only while the table is being streamed out.
  assign in_ready      = !reset && (state != ST_REPLAY);
  assign accept        = in_valid && in_ready;
  // A word whose min exceeds its max is repaired by swapping halves.
  assign swap          = $signed(in_data[15:0]) > $signed(in_data[31:16]);
  assign wr_word       = swap ? {in_data[15:0], in_data[31:16]} : in_data;
  assign idx_inc       = {1'b0, idx} + ONE_W;
  assign limbuff_valid = (state == ST_REPLAY);
  assign limbuff_data  = rd_data;

  // Next-state and datapath control; a sop word restarts loading from any non-replay state.
  always_comb begin
    state_nxt     = state;
    wp_nxt        = wp;
    idx_nxt       = idx;
    table_len_nxt = table_len;
    cnt_nxt       = iter_count;
    cfg_nxt       = cfg_error;
    ovf_nxt       = overflow;
    load_done_nxt = 1'b0;
    iter_done_nxt = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = wp[ADDR_WIDTH-1:0];

    if (accept && in_startofpacket) begin
      wr_en         = 1'b1;
      wr_addr       = '0;
      wp_nxt        = ONE_W;
      cfg_nxt       = swap;
      ovf_nxt       = 1'b0;
      cnt_nxt       = '0;
      table_len_nxt = '0;
      state_nxt     = ST_LOAD;
      if (in_endofpacket) begin
        table_len_nxt = ONE_W;
        load_done_nxt = 1'b1;
        state_nxt     = ST_READY;
      end
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            if (wp == DEPTH_W) begin
              ovf_nxt = 1'b1;
            end else begin
              wr_en  = 1'b1;
              wp_nxt = wp + ONE_W;
              if (swap) cfg_nxt = 1'b1;
            end
            if (in_endofpacket) begin
              table_len_nxt = wp_nxt;
              load_done_nxt = 1'b1;
              state_nxt     = ST_READY;
            end
          end
        end
        ST_READY: begin
          if (iter_start) begin
            idx_nxt   = '0;
            state_nxt = ST_REPLAY;
          end
        end
        ST_REPLAY: begin
          if (iter_advance) begin
            if (idx_inc == table_len) begin
              iter_done_nxt = 1'b1;
              cnt_nxt       = iter_count + CNT_ONE;
              state_nxt     = ST_READY;
            end else begin
              idx_nxt = idx_inc[ADDR_WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      wp         <= '0;
      idx        <= '0;
      table_len  <= '0;
      iter_count <= '0;
      cfg_error  <= 1'b0;
      overflow   <= 1'b0;
      load_done  <= 1'b0;
      iter_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      wp         <= wp_nxt;
      idx        <= idx_nxt;
      table_len  <= table_len_nxt;
      iter_count <= cnt_nxt;
      cfg_error  <= cfg_nxt;
      overflow   <= ovf_nxt;
      load_done  <= load_done_nxt;
      iter_done  <= iter_done_nxt;
    end
  end

  // Table RAM write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  // Registered read addressed by next-cycle index so each advance shows the new word immediately.
  always_ff @(posedge clock) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[idx_nxt];
  end

endmodule

// File: tb/tb_limits_buffer_controller.sv
// Randomized bench for limits_buffer_controller against a queue/array level behavioural model.
// Checks every output each cycle on the falling edge, plus directed spot values.
// Drives inputs 1 time unit after the rising edge.
module tb_limits_buffer_controller;

  localparam int AW = 2;
  localparam int CW = 3;
  localparam int DEPTH = 4;

  logic          clock;
  logic          reset;
  logic [31:0]   in_data;
  logic          in_valid, in_startofpacket, in_endofpacket, in_ready;
  logic          iter_start, iter_advance;
  logic [31:0]   limbuff_data;
  logic          limbuff_valid, iter_done, load_done, cfg_error, overflow;
  logic [AW:0]   table_len;
  logic [CW-1:0] iter_count;

  limits_buffer_controller #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .in_ready(in_ready),
    .iter_start(iter_start), .iter_advance(iter_advance),
    .limbuff_data(limbuff_data), .limbuff_valid(limbuff_valid),
    .iter_done(iter_done), .load_done(load_done),
    .table_len(table_len), .iter_count(iter_count),
    .cfg_error(cfg_error), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=no table, 1=loading, 2=table ready, 3=replaying.
  int          m_mode = 0, m_wp = 0, m_len = 0, m_idx = 0, m_cnt = 0, m_old = 0;
  logic [31:0] m_mem [DEPTH];
  bit          m_cfg = 0, m_ovf = 0, m_ld = 0, m_dn = 0, m_after_rst = 0, chk_en = 0, m_acc = 0;

  task automatic m_store(input logic [31:0] w);
    if (m_wp == DEPTH) begin
      m_ovf = 1;
    end else begin
      if ($signed(w[15:0]) > $signed(w[31:16])) begin
        m_mem[m_wp] = {w[15:0], w[31:16]};
        m_cfg = 1;
      end else begin
        m_mem[m_wp] = w;
      end
      m_wp++;
    end
    if (in_endofpacket) begin
      m_len = m_wp;
      m_mode = 2;
      m_ld = 1;
    end
  endtask

  always @(posedge clock) begin
    m_ld = 0;
    m_dn = 0;
    m_after_rst = 0;
    m_old = m_mode;
    if (reset) begin
      m_mode = 0; m_len = 0; m_cnt = 0; m_cfg = 0; m_ovf = 0; m_wp = 0; m_idx = 0;
      chk_en = 1;
      m_after_rst = 1;
    end else begin
      m_acc = in_valid && (m_old != 3);
      if (m_acc && in_startofpacket) begin
        m_wp = 0; m_cfg = 0; m_ovf = 0; m_cnt = 0; m_len = 0; m_mode = 1;
        m_store(in_data);
      end else if (m_acc && m_old == 1) begin
        m_store(in_data);
      end else if (m_old == 2 && iter_start) begin
        m_mode = 3;
        m_idx = 0;
      end else if (m_old == 3 && iter_advance) begin
        if (m_idx == m_len - 1) begin
          m_mode = 2;
          m_dn = 1;
          m_cnt = (m_cnt + 1) % (1 << CW);
        end else begin
          m_idx++;
        end
      end
    end
  end

  // Full output comparison every cycle.
  always @(negedge clock) begin
    if (chk_en) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, !reset && m_mode != 3});
      check("limbuff_valid", {31'd0, limbuff_valid}, {31'd0, m_mode == 3});
      if (m_mode == 3) check("limbuff_data", limbuff_data, m_mem[m_idx]);
      else if (m_after_rst) check("limbuff_data_rst", limbuff_data, 32'd0);
      check("load_done", {31'd0, load_done}, {31'd0, m_ld});
      check("iter_done", {31'd0, iter_done}, {31'd0, m_dn});
      check("table_len", 32'(table_len), 32'(m_len));
      check("iter_count", 32'(iter_count), 32'(m_cnt));
      check("cfg_error", {31'd0, cfg_error}, {31'd0, m_cfg});
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic sop, input logic eop);
    in_valid = 1; in_data = w; in_startofpacket = sop; in_endofpacket = eop;
    cyc();
    in_valid = 0; in_startofpacket = 0; in_endofpacket = 0;
  endtask

  task automatic replay_spaced(input int gap, input bit spurious);
    iter_start = 1;
    cyc();
    iter_start = 0;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        iter_start = spurious && (k == 1) && (g == 0);
        cyc();
        iter_start = 0;
      end
      iter_advance = 1;
      cyc();
      iter_advance = 0;
    end
    cyc();
  endtask

  logic [31:0] pkt [4];

  initial begin
    reset = 1; in_data = 0; in_valid = 0; in_startofpacket = 0; in_endofpacket = 0;
    iter_start = 0; iter_advance = 0;
    pkt[0] = 32'h0064FF9C; pkt[1] = 32'h00C8FF38; pkt[2] = 32'h0010FFF0; pkt[3] = 32'h7FFF8000;
    cyc(); cyc(); cyc();
    reset = 0;
    cyc();

    // Directed 4-word load.
    for (int i = 0; i < 4; i++) send(pkt[i], i == 0, i == 3);
    cyc();
    check("dir_table_len", 32'(table_len), 32'd4);

    // Back-to-back advances, then spaced advances with a spurious start.
    replay_spaced(0, 0);
    check("dir_iter_count1", 32'(iter_count), 32'd1);
    replay_spaced(2, 1);
    check("dir_iter_count2", 32'(iter_count), 32'd2);

    // Swapped limits word.
    send(32'hFF9C0064, 1, 1);
    iter_start = 1;
    cyc();
    iter_start = 0;
    check("dir_swap_word", limbuff_data, 32'h0064FF9C);
    check("dir_cfg_error", {31'd0, cfg_error}, 32'd1);
    iter_advance = 1;
    cyc();
    iter_advance = 0;
    cyc();

    // Overflowing 6-word packet.
    for (int i = 0; i < 6; i++) send(32'h00100000 + 32'(i), i == 0, i == 5);
    cyc();
    check("dir_ovf_len", 32'(table_len), 32'd4);
    check("dir_ovf_flag", {31'd0, overflow}, 32'd1);

    // Reset during replay at index 2, then a start that must be ignored.
    iter_start = 1; cyc(); iter_start = 0;
    iter_advance = 1; cyc(); cyc(); iter_advance = 0;
    check("dir_idx2_word", limbuff_data, 32'h00100002);
    reset = 1; cyc(); reset = 0;
    check("dir_rst_valid", {31'd0, limbuff_valid}, 32'd0);
    iter_start = 1; cyc(); iter_start = 0;
    check("dir_rst_ignore", {31'd0, limbuff_valid}, 32'd0);
    cyc();

    // Randomized loads, replays and resets.
    for (int t = 0; t < 300; t++) begin
      int action;
      action = $urandom_range(0, 19);
      if (action == 0) begin
        reset = 1; cyc(); reset = 0;
      end else if (action < 9) begin
        int len;
        bit nosop, noeop;
        len = $urandom_range(1, 6);
        nosop = ($urandom_range(0, 7) == 0);
        noeop = ($urandom_range(0, 7) == 0);
        for (int i = 0; i < len; i++) begin
          while ($urandom_range(0, 3) == 0) cyc();
          send($urandom, (i == 0) && !nosop, (i == len - 1) && !noeop);
        end
      end else begin
        iter_start = 1;
        iter_advance = $urandom_range(0, 1);
        cyc();
        iter_start = 0;
        for (int k = 0; k < 60 && m_mode == 3; k++) begin
          iter_advance = $urandom_range(0, 1);
          iter_start = ($urandom_range(0, 7) == 0);
          in_valid = ($urandom_range(0, 5) == 0);
          in_startofpacket = in_valid;
          in_endofpacket = in_valid;
          in_data = $urandom;
          cyc();
        end
        iter_advance = 0; iter_start = 0;
        in_valid = 0; in_startofpacket = 0; in_endofpacket = 0;
        cyc();
      end
    end
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
